// File: rtl/fwd_track_unit.sv
// Operand forwarding and load-use hazard tracker: remembers which register each in-flight
// producer stage will write, steers decode operands to the youngest producer, and stalls on unready data.
module fwd_track_unit #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 3,
    parameter int REGBITS = 5,
    parameter int SELW    = 2
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Advance,
    input  logic                   Flush,
    input  logic                   IssueValid,
    input  logic                   IssueWrites,
    input  logic [REGBITS-1:0]     IssueDest,
    input  logic                   IssueUsesRt,
    input  logic [REGBITS-1:0]     RsAddr,
    input  logic [REGBITS-1:0]     RtAddr,
    input  logic [WIDTH-1:0]       RsRegData,
    input  logic [WIDTH-1:0]       RtRegData,
    input  logic [DEPTH*WIDTH-1:0] StageData,
    input  logic [DEPTH-1:0]       StageDataValid,
    output logic [WIDTH-1:0]       RsOut,
    output logic [WIDTH-1:0]       RtOut,
    output logic [SELW-1:0]        RsSel,
    output logic [SELW-1:0]        RtSel,
    output logic                   Stall,
    output logic [15:0]            StallCount
);

    // Issue protocol: an instruction is accepted into stage 0 on an edge with Advance=1
    // and Stall=0; while Stall=1 the decode slot holds and a bubble enters the pipe instead.

    logic [DEPTH-1:0]   entryValid;
    logic [REGBITS-1:0] entryDest [DEPTH];

    logic [DEPTH-1:0] rsMatch;
    logic [DEPTH-1:0] rtMatch;
    logic             rsHazard;
    logic             rtHazard;
    logic             issueTracked;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rsMatch[i] = entryValid[i] && (entryDest[i] == RsAddr) && (RsAddr != '0);
            rtMatch[i] = entryValid[i] && (entryDest[i] == RtAddr) && (RtAddr != '0);
        end
    end

    // Walk from oldest to youngest so the youngest matching producer overrides the rest.
    always_comb begin
        RsSel    = '0;
        RsOut    = RsRegData;
        rsHazard = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rsMatch[i]) begin
                RsSel    = SELW'(i + 1);
                RsOut    = StageData[i*WIDTH +: WIDTH];
                rsHazard = ~StageDataValid[i];
            end
        end
    end

    always_comb begin
        RtSel    = '0;
        RtOut    = RtRegData;
        rtHazard = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rtMatch[i]) begin
                RtSel    = SELW'(i + 1);
                RtOut    = StageData[i*WIDTH +: WIDTH];
                rtHazard = ~StageDataValid[i];
            end
        end
    end

    always_comb begin
        Stall        = IssueValid && (rsHazard || (IssueUsesRt && rtHazard));
        issueTracked = IssueValid && IssueWrites && !Stall && (IssueDest != '0);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            entryValid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entryDest[i] <= '0;
            end
        end else if (Flush) begin
            entryValid <= '0;
        end else if (Advance) begin
            for (int i = 1; i < DEPTH; i++) begin
                entryValid[i] <= entryValid[i-1];
                entryDest[i]  <= entryDest[i-1];
            end
            entryValid[0] <= issueTracked;
            entryDest[0]  <= issueTracked ? IssueDest : '0;
        end
    end

    // Counts stalled cycles even when the pipe is frozen; only Reset clears it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            StallCount <= '0;
        end else if (Stall && (StallCount != 16'hFFFF)) begin
            StallCount <= StallCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_fwd_track_unit.sv
// Bench for fwd_track_unit: directed scenarios plus random traffic, checked against a
// queue-of-destinations model of the in-flight producers.
module tb_fwd_track_unit;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 3;
    localparam int REGBITS = 5;
    localparam int SELW    = 2;

    logic                   Clk = 1'b0;
    logic                   Reset;
    logic                   Advance;
    logic                   Flush;
    logic                   IssueValid;
    logic                   IssueWrites;
    logic [REGBITS-1:0]     IssueDest;
    logic                   IssueUsesRt;
    logic [REGBITS-1:0]     RsAddr;
    logic [REGBITS-1:0]     RtAddr;
    logic [WIDTH-1:0]       RsRegData;
    logic [WIDTH-1:0]       RtRegData;
    logic [DEPTH*WIDTH-1:0] StageData;
    logic [DEPTH-1:0]       StageDataValid;
    logic [WIDTH-1:0]       RsOut;
    logic [WIDTH-1:0]       RtOut;
    logic [SELW-1:0]        RsSel;
    logic [SELW-1:0]        RtSel;
    logic                   Stall;
    logic [15:0]            StallCount;

    fwd_track_unit #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .REGBITS(REGBITS), .SELW(SELW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Advance(Advance), .Flush(Flush),
        .IssueValid(IssueValid), .IssueWrites(IssueWrites), .IssueDest(IssueDest),
        .IssueUsesRt(IssueUsesRt), .RsAddr(RsAddr), .RtAddr(RtAddr),
        .RsRegData(RsRegData), .RtRegData(RtRegData), .StageData(StageData),
        .StageDataValid(StageDataValid), .RsOut(RsOut), .RtOut(RtOut),
        .RsSel(RsSel), .RtSel(RtSel), .Stall(Stall), .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    int nCmp = 0;
    int nErr = 0;

    // Model: prodQ[i] is the register stage i will write, 0 meaning nothing tracked there.
    int prodQ[$];
    int expCount;
    int expRsSel, expRtSel;
    logic [WIDTH-1:0] expRsOut, expRtOut;
    logic expStall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int findProd(input logic [REGBITS-1:0] addr);
        for (int i = 0; i < DEPTH; i++) begin
            if (addr != 0 && prodQ[i] == int'(addr)) return i;
        end
        return -1;
    endfunction

    task automatic computeExp();
        int rs, rt;
        logic rsHaz, rtHaz;
        rs = findProd(RsAddr);
        rt = findProd(RtAddr);
        expRsSel = rs + 1;
        expRtSel = rt + 1;
        expRsOut = (rs < 0) ? RsRegData : StageData[rs*WIDTH +: WIDTH];
        expRtOut = (rt < 0) ? RtRegData : StageData[rt*WIDTH +: WIDTH];
        rsHaz = (rs >= 0) && !StageDataValid[rs];
        rtHaz = (rt >= 0) && !StageDataValid[rt] && IssueUsesRt;
        expStall = IssueValid && (rsHaz || rtHaz);
    endtask

    task automatic modelEdge();
        if (Reset) begin
            prodQ = '{0, 0, 0};
            expCount = 0;
        end else begin
            if (expStall && expCount < 65535) expCount++;
            if (Flush) begin
                prodQ = '{0, 0, 0};
            end else if (Advance) begin
                prodQ.push_front((IssueValid && IssueWrites && !expStall) ? int'(IssueDest) : 0);
                void'(prodQ.pop_back());
            end
        end
    endtask

    // Check all outputs against the model, then clock one edge and update the model.
    task automatic cycle();
        #1;
        computeExp();
        chk("rs_sel", 32'(RsSel), 32'(expRsSel));
        chk("rt_sel", 32'(RtSel), 32'(expRtSel));
        chk("rs_out", RsOut, expRsOut);
        chk("rt_out", RtOut, expRtOut);
        chk("stall", 32'(Stall), 32'(expStall));
        chk("stall_count", 32'(StallCount), 32'(expCount));
        @(posedge Clk);
        modelEdge();
        #1;
    endtask

    task automatic quietCycle();
        #1;
        computeExp();
        @(posedge Clk);
        modelEdge();
        #1;
    endtask

    task automatic idleInputs();
        Reset = 1'b0; Advance = 1'b1; Flush = 1'b0;
        IssueValid = 1'b0; IssueWrites = 1'b0; IssueDest = '0; IssueUsesRt = 1'b0;
        RsAddr = '0; RtAddr = '0;
        RsRegData = $urandom; RtRegData = $urandom;
        StageData = {$urandom, $urandom, $urandom};
        StageDataValid = 3'b111;
    endtask

    task automatic doReset();
        idleInputs();
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
    endtask

    task automatic issue(input logic [REGBITS-1:0] dest);
        IssueValid = 1'b1; IssueWrites = 1'b1; IssueDest = dest;
        cycle();
        IssueValid = 1'b0; IssueWrites = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] slice0;
        int guard;
        prodQ = '{0, 0, 0};
        expCount = 0;
        idleInputs();
        Reset = 1'b1;
        @(posedge Clk);
        modelEdge();
        #1;
        doReset();

        // Post-reset: everything reads from the register file.
        RsAddr = 5'd5; RtAddr = 5'd9;
        chk("rst_rs_sel", 32'(RsSel), 32'd0);
        chk("rst_rt_out", RtOut, RtRegData);
        chk("rst_count", 32'(StallCount), 32'd0);
        cycle();

        // Single producer forwarded from stage 0.
        doReset();
        issue(5'd5);
        IssueValid = 1'b1; IssueWrites = 1'b1; IssueDest = 5'd5; RsAddr = 5'd5;
        StageData[WIDTH-1:0] = 32'hAAAA; StageDataValid = 3'b111;
        #1;
        chk("fwd_rs_sel", 32'(RsSel), 32'd1);
        chk("fwd_rs_out", RsOut, 32'hAAAA);
        chk("fwd_stall", 32'(Stall), 32'd0);
        cycle();

        // Same register in stages 0 and 1: youngest wins.
        IssueValid = 1'b0; IssueWrites = 1'b0; Advance = 1'b0;
        StageData[WIDTH +: WIDTH] = 32'hBBBB;
        #1;
        chk("young_rs_sel", 32'(RsSel), 32'd1);
        chk("young_rs_out", RsOut, 32'hAAAA);
        cycle();

        // Load-use on Rt.
        doReset();
        issue(5'd7);
        Advance = 1'b0; IssueValid = 1'b1; IssueWrites = 1'b1; IssueDest = 5'd3;
        RtAddr = 5'd7; IssueUsesRt = 1'b0; StageDataValid = 3'b110;
        #1;
        chk("ld_nort_stall", 32'(Stall), 32'd0);
        chk("ld_nort_rt_sel", 32'(RtSel), 32'd1);
        cycle();
        Advance = 1'b1; IssueUsesRt = 1'b1;
        #1;
        chk("ld_stall", 32'(Stall), 32'd1);
        cycle();
        IssueValid = 1'b0; Advance = 1'b0;
        #1;
        chk("ld_count", 32'(StallCount), 32'd1);
        chk("ld_bubble_rt_sel", 32'(RtSel), 32'd2);
        cycle();

        // Register 0 is never tracked.
        doReset();
        issue(5'd0);
        RsAddr = 5'd0;
        #1;
        chk("r0_rs_sel", 32'(RsSel), 32'd0);
        chk("r0_rs_out", RsOut, RsRegData);
        cycle();

        // Retirement after DEPTH advances, then Flush.
        doReset();
        issue(5'd9);
        RsAddr = 5'd9;
        for (int k = 0; k < DEPTH; k++) cycle();
        #1;
        chk("retire_rs_sel", 32'(RsSel), 32'd0);
        issue(5'd4);
        issue(5'd6);
        RsAddr = 5'd4; RtAddr = 5'd6;
        #1;
        chk("pre_flush_rs_sel", 32'(RsSel), 32'd2);
        Flush = 1'b1;
        cycle();
        Flush = 1'b0;
        #1;
        chk("flush_rs_sel", 32'(RsSel), 32'd0);
        chk("flush_rt_sel", 32'(RtSel), 32'd0);
        chk("flush_count", 32'(StallCount), 32'(expCount));
        cycle();

        // Random traffic.
        doReset();
        for (int k = 0; k < 600; k++) begin
            Reset = ($urandom_range(0, 49) == 0);
            Flush = ($urandom_range(0, 19) == 0);
            Advance = ($urandom_range(0, 3) != 0);
            IssueValid = $urandom_range(0, 1);
            IssueWrites = ($urandom_range(0, 3) != 0);
            IssueDest = REGBITS'($urandom_range(0, 7));
            IssueUsesRt = $urandom_range(0, 1);
            RsAddr = REGBITS'($urandom_range(0, 7));
            RtAddr = REGBITS'($urandom_range(0, 7));
            RsRegData = $urandom; RtRegData = $urandom;
            StageData = {$urandom, $urandom, $urandom};
            StageDataValid = DEPTH'($urandom_range(0, 7));
            cycle();
        end

        // Saturation: hold a frozen load-use stall until the counter nears its top.
        doReset();
        issue(5'd7);
        Advance = 1'b0; IssueValid = 1'b1; RsAddr = 5'd7; StageDataValid = 3'b000;
        guard = 0;
        while (expCount != 16'hFFFE && guard < 70000) begin
            quietCycle();
            guard++;
        end
        chk("sat_reach_guard", 32'(expCount), 32'hFFFE);
        chk("sat_fffe", 32'(StallCount), 32'hFFFE);
        cycle();
        cycle();
        #1;
        chk("sat_ffff", 32'(StallCount), 32'hFFFF);
        cycle();
        Reset = 1'b1;
        cycle();
        Reset = 1'b0; IssueValid = 1'b0;
        #1;
        chk("sat_reset", 32'(StallCount), 32'd0);
        chk("sat_reset_stall", 32'(Stall), 32'd0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
